// File: rtl/des_pipe_pkg.sv
// Shared types and constants for the DES pipe staging path.
// The word-order helper is also used by the input-side RAM loader, so both sides agree on it.
package des_pipe_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_PAD,
    S_DONE
  } stage_state_e;

  localparam int unsigned EntryW = 64;
  localparam int unsigned WordW  = 32;

  localparam logic [EntryW-1:0] PadEntry = 64'h0;

  // Low half leaves first, then the upper half.
  function automatic logic [WordW-1:0] pipe_word(input logic [EntryW-1:0] entry,
                                                 input logic              upper);
    return upper ? entry[EntryW-1:WordW] : entry[WordW-1:0];
  endfunction

endpackage

// File: rtl/des_pipeout_stager_if.sv
// Handshake and PipeOut signals of the DES output stager.
// The DES engine and host endpoint side is the master; the stager is the slave.
interface des_pipeout_stager_if #(
  parameter int unsigned DEPTH_ENTRIES = 256
);
  import des_pipe_pkg::*;

  localparam int unsigned LevelW = $clog2(2 * DEPTH_ENTRIES) + 1;

  logic              in_valid;
  logic [EntryW-1:0] in_data;
  logic              in_ready;
  logic              flush;
  logic              flush_done;
  logic              ep_read;
  logic [WordW-1:0]  ep_datain;
  logic              ep_ready;
  logic [LevelW-1:0] level;
  logic              underflow;

  modport master (
    output in_valid, in_data, flush, ep_read,
    input  in_ready, flush_done, ep_datain, ep_ready, level, underflow
  );

  modport slave (
    input  in_valid, in_data, flush, ep_read,
    output in_ready, flush_done, ep_datain, ep_ready, level, underflow
  );

endinterface

// File: rtl/des_stage_ram.sv
// Simple dual-port memory: synchronous write, asynchronous read.
module des_stage_ram #(
  parameter  int unsigned Depth = 256,
  parameter  int unsigned Width = 64,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/des_pipeout_stager.sv
// Buffers 64-bit DES results and serves them to a block-throttled PipeOut as 32-bit words,
// optionally zero-padding the tail of the stream up to a whole pipe block.
module des_pipeout_stager
  import des_pipe_pkg::*;
#(
  parameter int unsigned DEPTH_ENTRIES = 256,
  parameter int unsigned BLOCK_WORDS   = 256
) (
  input logic                 okClk,
  input logic                 reset,
  des_pipeout_stager_if.slave bus
);

  localparam int unsigned AddrW  = $clog2(DEPTH_ENTRIES);
  localparam int unsigned LevelW = $clog2(2 * DEPTH_ENTRIES) + 1;
  localparam int unsigned TailW  = $clog2(BLOCK_WORDS);

  // An entry fits only if two free word slots remain.
  localparam logic [LevelW-1:0] SpaceMax = LevelW'(2 * DEPTH_ENTRIES - 2);
  localparam logic [LevelW-1:0] BlockLvl = LevelW'(BLOCK_WORDS);

  stage_state_e      state_q, state_d;
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic              rd_half_q;
  logic [LevelW-1:0] level_q, level_d;
  logic [TailW-1:0]  tail_cnt_q;
  logic              ep_ready_q;
  logic              underflow_q;

  logic              has_space;
  logic              in_ready;
  logic              accept;
  logic              pad_wr;
  logic              wr_en;
  logic              rd_ok;
  logic              flush_done;
  logic [EntryW-1:0] wr_data;
  logic [EntryW-1:0] rd_entry;

  assign has_space = (level_q <= SpaceMax);
  assign accept    = bus.in_valid && in_ready;
  assign wr_en     = accept || pad_wr;
  assign wr_data   = pad_wr ? PadEntry : bus.in_data;
  assign rd_ok     = bus.ep_read && (level_q != '0);

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    pad_wr     = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      S_RUN: begin
        in_ready = has_space;
        if (bus.flush) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (tail_cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          pad_wr = has_space;
        end
      end
      S_DONE: begin
        flush_done = 1'b1;
        state_d    = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (wr_en) begin
      level_d = level_d + LevelW'(2);
    end
    if (rd_ok) begin
      level_d = level_d - LevelW'(1);
    end
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q     <= S_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_half_q   <= 1'b0;
      level_q     <= '0;
      tail_cnt_q  <= '0;
      ep_ready_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      ep_ready_q <= (level_d >= BlockLvl);
      if (wr_en) begin
        wr_ptr_q   <= wr_ptr_q + AddrW'(1);
        // Block size is a power of two, so natural wrap gives the modulo.
        tail_cnt_q <= tail_cnt_q + TailW'(2);
      end
      if (rd_ok) begin
        rd_half_q <= ~rd_half_q;
        if (rd_half_q) begin
          rd_ptr_q <= rd_ptr_q + AddrW'(1);
        end
      end
      if (bus.ep_read && (level_q == '0)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  des_stage_ram #(
    .Depth (DEPTH_ENTRIES),
    .Width (EntryW)
  ) u_ram (
    .clk_i   (okClk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign bus.in_ready   = in_ready;
  assign bus.flush_done = flush_done;
  assign bus.ep_datain  = pipe_word(rd_entry, rd_half_q);
  assign bus.ep_ready   = ep_ready_q;
  assign bus.level      = level_q;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_des_pipeout_stager.sv
// Self-checking bench for des_pipeout_stager: vector table, flush/reset corner sequences,
// and a randomized run against a word-queue reference model.
module tb_des_pipeout_stager;

  localparam int unsigned Depth = 256;
  localparam int unsigned Block = 256;

  logic okClk;
  logic reset;

  des_pipeout_stager_if #(.DEPTH_ENTRIES(Depth)) bus ();

  des_pipeout_stager #(
    .DEPTH_ENTRIES (Depth),
    .BLOCK_WORDS   (Block)
  ) dut (
    .okClk (okClk),
    .reset (reset),
    .bus   (bus)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          valid;
    logic [63:0] data;
    bit          read;
    int          exp_level;
    logic [31:0] exp_word;
    bit          word_ok;
    bit          exp_uf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge okClk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.ep_read  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop();
    bus.ep_read = 1'b1;
    step();
    bus.ep_read = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  // Steps up to budget cycles; reports the first cycle flush_done was seen and how often.
  task automatic watch_done(input int budget, output int first_j, output int pulses);
    first_j = -1;
    pulses  = 0;
    for (int j = 1; j <= budget; j++) begin
      step();
      if (bus.flush_done) begin
        pulses++;
        if (first_j < 0) first_j = j;
      end
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v, ~v};
  endfunction

  logic [31:0] mq[$];
  bit          m_uf;

  initial begin
    int first_j;
    int pulses;
    logic [63:0] e;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    bus.ep_read  = 1'b0;

    vecs[0] = '{1'b1, 64'hA1A1A1A1_A0A0A0A0, 1'b0, 2, 32'hA0A0A0A0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 64'hB1B1B1B1_B0B0B0B0, 1'b1, 3, 32'hA1A1A1A1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 64'h0,                 1'b1, 2, 32'hB0B0B0B0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 64'h0,                 1'b1, 1, 32'hB1B1B1B1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 64'h0,                 1'b1, 0, 32'h0,        1'b0, 1'b0};
    vecs[5] = '{1'b0, 64'h0,                 1'b1, 0, 32'h0,        1'b0, 1'b1};
    vecs[6] = '{1'b1, 64'hC1C1C1C1_C0C0C0C0, 1'b1, 2, 32'hC0C0C0C0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 64'h0,                 1'b0, 2, 32'hC0C0C0C0, 1'b1, 1'b1};

    // Reset values
    do_reset();
    chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
    chk("rst_ep_ready",   64'(bus.ep_ready),   64'd0);
    chk("rst_level",      64'(bus.level),      64'd0);
    chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
    chk("rst_underflow",  64'(bus.underflow),  64'd0);

    // Vector table
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = vecs[k].valid;
      bus.in_data  = vecs[k].data;
      bus.ep_read  = vecs[k].read;
      step();
      bus.in_valid = 1'b0;
      bus.ep_read  = 1'b0;
      chk($sformatf("vec%0d_level", k), 64'(bus.level), 64'(vecs[k].exp_level));
      chk($sformatf("vec%0d_uf", k), 64'(bus.underflow), 64'(vecs[k].exp_uf));
      chk($sformatf("vec%0d_in_ready", k), 64'(bus.in_ready), 64'd1);
      chk($sformatf("vec%0d_ep_ready", k), 64'(bus.ep_ready), 64'd0);
      if (vecs[k].word_ok) chk($sformatf("vec%0d_word", k), 64'(bus.ep_datain), 64'(vecs[k].exp_word));
    end

    // 128 entries then 256 reads; ep_ready follows the level threshold
    do_reset();
    for (int i = 0; i < 128; i++) begin
      push(pat(i));
      chk($sformatf("t1_level_%0d", i), 64'(bus.level), 64'(2 * (i + 1)));
      chk($sformatf("t1_ep_ready_%0d", i), 64'(bus.ep_ready), 64'(2 * (i + 1) >= 256));
    end
    for (int w = 0; w < 256; w++) begin
      e = pat(w / 2);
      chk($sformatf("t1_word_%0d", w), 64'(bus.ep_datain), (w % 2 == 0) ? 64'(e[31:0]) : 64'(e[63:32]));
      pop();
      if (w == 0) chk("t1_ep_ready_fall", 64'(bus.ep_ready), 64'd0);
    end
    chk("t1_level_end", 64'(bus.level), 64'd0);
    chk("t1_underflow", 64'(bus.underflow), 64'd0);

    // Full buffer and in_ready recovery
    do_reset();
    for (int i = 0; i < 256; i++) push(pat(i));
    chk("t2_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t2_full_level", 64'(bus.level), 64'd512);
    pop();
    chk("t2_level_511", 64'(bus.level), 64'd511);
    chk("t2_in_ready_511", 64'(bus.in_ready), 64'd0);
    chk("t2_word_after1", 64'(bus.ep_datain), 64'h0);
    pop();
    chk("t2_level_510", 64'(bus.level), 64'd510);
    chk("t2_in_ready_510", 64'(bus.in_ready), 64'd1);
    chk("t2_word_after2", 64'(bus.ep_datain), 64'hFFFFFFFE);

    // Unaligned flush: 3 entries then 125 pad entries
    do_reset();
    for (int i = 0; i < 3; i++) push({32'hDEAD0000 ^ 32'(i), 32'h100 + 32'(i)});
    pulse_flush();
    chk("t3_pad_in_ready", 64'(bus.in_ready), 64'd0);
    watch_done(140, first_j, pulses);
    chk("t3_done_cycle", 64'(first_j), 64'd126);
    chk("t3_done_pulses", 64'(pulses), 64'd1);
    chk("t3_level", 64'(bus.level), 64'd256);
    chk("t3_ep_ready", 64'(bus.ep_ready), 64'd1);
    for (int w = 0; w < 256; w++) begin
      if (w < 6) begin
        e = {32'hDEAD0000 ^ 32'(w / 2), 32'h100 + 32'(w / 2)};
        chk($sformatf("t3_word_%0d", w), 64'(bus.ep_datain), (w % 2 == 0) ? 64'(e[31:0]) : 64'(e[63:32]));
      end else begin
        chk($sformatf("t3_word_%0d", w), 64'(bus.ep_datain), 64'h0);
      end
      pop();
    end

    // Aligned flush: no padding, done two cycles after flush
    do_reset();
    for (int i = 0; i < 128; i++) push(pat(i));
    pulse_flush();
    chk("t4_no_done_yet", 64'(bus.flush_done), 64'd0);
    step();
    chk("t4_done", 64'(bus.flush_done), 64'd1);
    chk("t4_level", 64'(bus.level), 64'd256);
    step();
    chk("t4_done_once", 64'(bus.flush_done), 64'd0);
    chk("t4_level_after", 64'(bus.level), 64'd256);
    chk("t4_in_ready", 64'(bus.in_ready), 64'd1);

    // Underflow is sticky until reset
    do_reset();
    pop();
    chk("t5_level", 64'(bus.level), 64'd0);
    chk("t5_uf_set", 64'(bus.underflow), 64'd1);
    for (int i = 0; i < 5; i++) step();
    chk("t5_uf_sticky", 64'(bus.underflow), 64'd1);
    do_reset();
    chk("t5_uf_clear", 64'(bus.underflow), 64'd0);

    // Reset in the middle of padding, then a fresh stream
    do_reset();
    for (int i = 0; i < 3; i++) push(pat(i));
    pulse_flush();
    for (int i = 0; i < 10; i++) step();
    chk("t6_level_midpad", 64'(bus.level), 64'd26);
    do_reset();
    chk("t6_level_rst", 64'(bus.level), 64'd0);
    chk("t6_in_ready_rst", 64'(bus.in_ready), 64'd1);
    watch_done(130, first_j, pulses);
    chk("t6_no_done", 64'(pulses), 64'd0);
    chk("t6_level_idle", 64'(bus.level), 64'd0);
    push(64'h77777777_66666666);
    chk("t6_fresh_level", 64'(bus.level), 64'd2);
    chk("t6_fresh_word", 64'(bus.ep_datain), 64'h66666666);
    push(64'h99999999_88888888);
    pulse_flush();
    watch_done(140, first_j, pulses);
    chk("t6_fresh_done_cycle", 64'(first_j), 64'd127);
    chk("t6_fresh_pulses", 64'(pulses), 64'd1);
    chk("t6_fresh_level_end", 64'(bus.level), 64'd256);

    // Randomized traffic against a word-queue model
    do_reset();
    mq.delete();
    m_uf = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      int pw;
      int pr;
      pw = (ph == 0) ? 90 : (ph == 1) ? 30 : 60;
      pr = (ph == 0) ? 30 : (ph == 1) ? 90 : 60;
      for (int c = 0; c < 600; c++) begin
        bit          v;
        bit          r;
        bit          exp_rdy;
        logic [63:0] d;
        v = ($urandom_range(99) < pw);
        r = ($urandom_range(99) < pr);
        d = {$urandom, $urandom};
        exp_rdy = (mq.size() <= 2 * Depth - 2);
        chk("rnd_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        bus.in_valid = v;
        bus.in_data  = d;
        bus.ep_read  = r;
        step();
        bus.in_valid = 1'b0;
        bus.ep_read  = 1'b0;
        if (r) begin
          if (mq.size() > 0) void'(mq.pop_front());
          else m_uf = 1'b1;
        end
        if (v && exp_rdy) begin
          mq.push_back(d[31:0]);
          mq.push_back(d[63:32]);
        end
        chk("rnd_level", 64'(bus.level), 64'(mq.size()));
        chk("rnd_ep_ready", 64'(bus.ep_ready), 64'(mq.size() >= Block));
        chk("rnd_underflow", 64'(bus.underflow), 64'(m_uf));
        if (mq.size() > 0) chk("rnd_word", 64'(bus.ep_datain), 64'(mq[0]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_pipeout_stager.md
# des_pipeout_stager

Output staging buffer between the DES block engine and a block-throttled PipeOut endpoint. It accepts 64-bit DES result blocks over a valid/ready handshake and stores them in an internal buffer. It serializes each block to the host as two 32-bit pipe words, low half first. It asserts `ep_ready` whenever at least one full pipe block is buffered, and on request it zero-pads a partial tail so the host can always read whole blocks.

## Interface
- `DEPTH_ENTRIES`, default 256: buffer depth in 64-bit entries (512 pipe words). Power of two.
- `BLOCK_WORDS`, default 256: pipe block size in 32-bit words. Even, power of two, ≤ 2·DEPTH_ENTRIES.
- `okClk` in 1: sole clock, all logic on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `in_valid` in 1: DES result available.
- `in_data` in 64: DES result; [31:0] is sent first, then [63:32].
- `in_ready` out 1: entry accepted on a cycle where `in_valid && in_ready`.
- `flush` in 1: single-cycle request to pad to a block boundary.
- `flush_done` out 1: one-cycle pulse when padding is complete.
- `ep_read` in 1: PipeOut read strobe; consumes the current `ep_datain` word.
- `ep_datain` out 32: current head word.
- `ep_ready` out 1: level ≥ BLOCK_WORDS.
- `level` out $clog2(2·DEPTH_ENTRIES)+1: buffered pipe words.
- `underflow` out 1: sticky; an `ep_read` arrived while level was 0.

## Operation
- Storage: DEPTH_ENTRIES × 64 memory with asynchronous read, write pointer `wr_ptr`, read pointer `rd_ptr`, and a half-select bit `rd_half`. Pointers wrap modulo DEPTH_ENTRIES.
- `ep_datain` = `rd_half` ? mem[rd_ptr][63:32] : mem[rd_ptr][31:0]. The value is don't-care while level = 0.
- Read path:
  - `ep_read` with level > 0 toggles `rd_half`.
  - On the 1→0 toggle, `rd_ptr` increments.
  - Level decrements by 1.
- Write path: each accepted entry writes mem[wr_ptr], increments `wr_ptr`, and adds 2 to level.
- `tail_cnt`: words written modulo BLOCK_WORDS, advancing by 2 per write (both data and pad writes).
- State machine:
  - S_RUN:
    - `in_ready` = (level ≤ 2·DEPTH_ENTRIES − 2).
    - A `flush` pulse moves to S_PAD. Any entry accepted in the same cycle is counted before padding.
  - S_PAD:
    - `in_ready` = 0.
    - If `tail_cnt` = 0, go to S_DONE.
    - Otherwise, if space exists, write 64'h0 (zero pad) and advance `tail_cnt`.
    - If no space, wait without writing.
  - S_DONE: `flush_done` = 1 for one cycle, then return to S_RUN.
- `flush` is ignored while in S_PAD or S_DONE.
- Simultaneous write and read: level becomes level + 2 − 1.
- Read while empty: the read is ignored (no pointer or level change) and `underflow` is set. Only `reset` clears `underflow`.
- Reset mid-operation: pointers, level, `tail_cnt`, and `rd_half` return to 0; state goes to S_RUN; any padding in progress is abandoned.

## Timing
- Values after reset:
  - `in_ready` = 1.
  - `ep_ready` = 0.
  - `level` = 0.
  - `flush_done` = 0.
  - `underflow` = 0.
  - `ep_datain` = don't-care.
- Acceptance at edge N: level and `ep_ready` reflect the entry from edge N, and its low word is on `ep_datain` during cycle N+1.
- `ep_read` sampled at edge N: the next word is on `ep_datain` during cycle N+1. Sustained one-word-per-cycle reads are supported.
- `ep_ready` is a registered compare of the updated level. It falls in the cycle after the read that takes level below BLOCK_WORDS.
- Flush latency when already aligned: `flush` at edge N, S_PAD at N+1, S_DONE at N+2, `flush_done` high during cycle N+2.
- Flush latency when unaligned: one pad entry per cycle while space exists. With no stalls, `flush_done` is high during cycle N + 2 + (BLOCK_WORDS − tail_cnt)/2.

## Structure
- Shared package `des_pipe_pkg`:
  - State enum {S_RUN, S_PAD, S_DONE}.
  - Pad word constant 64'h0.
  - Word-order convention (low half first), shared with the input-side RAM loader.
- One sub-module: `des_stage_ram`, a simple dual-port memory with synchronous write and asynchronous read, parameterized by depth and width.
- FSM, pointers, and counters live in the top module.

## Test plan
- Reset, then push 128 entries with in_data = {i, ~i}, then read 256 words → `ep_ready` rises when level reaches 256; words read are ~0, 0, ~1, 1, …; `underflow` stays 0.
- Fill to 256 entries → `in_ready` = 0 and level = 512; one `ep_read` → level = 511 with `in_ready` still 0; a second `ep_read` → level = 510 and `in_ready` returns to 1.
- Push 3 entries, then pulse `flush` → 125 zero entries are written; level = 256; `ep_ready` = 1; `flush_done` pulses exactly once.
- Push 128 entries (aligned), then pulse `flush` → no pad writes; `flush_done` pulses 2 cycles after `flush`.
- Pulse `ep_read` at level 0 → level stays 0 and `underflow` = 1 and remains set; `reset` → `underflow` = 0.
- Pulse `reset` mid-pad (after 10 pad writes) → level = 0, FSM in S_RUN, no `flush_done` pulse; the next push behaves as a fresh stream.
